// File: rtl/prime_sequencer.sv
// Sweeps candidates 2 .. 2^WIDTH-1, tests each by trial division with repeated
// subtraction, and streams every prime out over a valid/ready handshake.
module prime_sequencer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] prime,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CAND_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEXT  = 3'd1,
        CHECK = 3'd2,
        MOD   = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] prime_d, count_d;
    logic             valid_d, busy_d, done_d;

    // State register plus datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            prime   <= '0;
            count   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            prime   <= prime_d;
            count   <= count_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = NEXT;
            NEXT:  state_d = (cand_q == CAND_MAX) ? DONE : CHECK;
            CHECK: state_d = (div_q == cand_q) ? EMIT : MOD;
            MOD: begin
                if (rem_q >= div_q) begin
                    state_d = MOD;
                end else if (rem_q == '0) begin
                    state_d = NEXT;
                end else begin
                    state_d = CHECK;
                end
            end
            EMIT:  if (ready) state_d = (cand_q == CAND_MAX) ? DONE : NEXT;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates; status flags track the state being entered
    always_comb begin
        cand_d  = cand_q;
        div_d   = div_q;
        rem_d   = rem_q;
        prime_d = prime;
        count_d = count;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cand_d  = WIDTH'(1);
                    count_d = '0;
                end
            end
            NEXT: begin
                if (cand_q != CAND_MAX) begin
                    cand_d = cand_q + WIDTH'(1);
                    div_d  = WIDTH'(2);
                end
            end
            CHECK: begin
                if (div_q == cand_q) begin
                    prime_d = cand_q;
                end else begin
                    rem_d = cand_q;
                end
            end
            MOD: begin
                if (rem_q >= div_q) begin
                    rem_d = rem_q - div_q;
                end else if (rem_q != '0) begin
                    div_d = div_q + WIDTH'(1);
                end
            end
            EMIT: begin
                if (ready) count_d = count + WIDTH'(1);
            end
            default: ;
        endcase
        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

endmodule

// File: tb/tb_prime_sequencer.sv
// Directed bench for prime_sequencer: full sweeps at WIDTH=5 and WIDTH=4,
// latency, backpressure, ignored starts, restart and mid-emit reset.
module tb_prime_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_t, ready_t;
    logic       sel;
    logic       start5, start4;
    logic [4:0] prime5, count5;
    logic [3:0] prime4, count4;
    logic       valid5, busy5, done5;
    logic       valid4, busy4, done4;

    int errors = 0;
    int checks = 0;

    int got[$];
    int done_cnt;
    int first_k;
    bit done_after_max;

    int exp5[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
    int exp4[6]  = '{2, 3, 5, 7, 11, 13};

    localparam int BUDGET = 5000;

    assign start5 = start_t && !sel;
    assign start4 = start_t && sel;

    prime_sequencer #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .ready(ready_t),
        .prime(prime5), .valid(valid5), .busy(busy5), .done(done5), .count(count5)
    );

    prime_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .ready(ready_t),
        .prime(prime4), .valid(valid4), .busy(busy4), .done(done4), .count(count4)
    );

    logic [31:0] obs_prime, obs_count;
    logic        obs_valid, obs_busy, obs_done;
    always_comb begin
        obs_prime = sel ? 32'(prime4) : 32'(prime5);
        obs_count = sel ? 32'(count4) : 32'(count5);
        obs_valid = sel ? valid4 : valid5;
        obs_busy  = sel ? busy4 : busy5;
        obs_done  = sel ? done4 : done5;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sweep on the selected instance; optional backpressure at 7 and stray starts
    task automatic sweep(input bit bp, input bit poke);
        int  k;
        int  n;
        int  exp_v;
        bit  bp_done;
        bit  prev_max;
        int  maxp;
        got.delete();
        done_cnt       = 0;
        first_k        = -1;
        done_after_max = 1'b0;
        bp_done        = 1'b0;
        prev_max       = 1'b0;
        maxp           = sel ? 13 : 31;
        @(negedge clk);
        start_t = 1'b1;
        ready_t = 1'b1;
        k = 0;
        while (k < BUDGET) begin
            @(negedge clk);
            k++;
            start_t = 1'b0;
            if (k == 1) begin
                chk("busy_rise", 32'(obs_busy), 1);
                chk("valid_lat0", 32'(obs_valid), 0);
                chk("count_clr", obs_count, 0);
            end
            if (poke && k == 20) start_t = 1'b1;
            if (obs_done) begin
                done_cnt++;
                done_after_max = prev_max;
                if (poke) start_t = 1'b1;
            end
            if (obs_valid && first_k < 0) first_k = k;
            if (bp && !bp_done && obs_valid && obs_prime == 7) begin
                ready_t = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    k++;
                    chk("bp_valid", 32'(obs_valid), 1);
                    chk("bp_prime", obs_prime, 7);
                    chk("bp_count", obs_count, 3);
                end
                ready_t = 1'b1;
                bp_done = 1'b1;
            end
            prev_max = obs_valid && ready_t && (obs_prime == 32'(maxp));
            if (obs_valid && ready_t) got.push_back(int'(obs_prime));
            if (!obs_busy && k > 1) break;
        end
        chk("sweep_timeout", 32'(k < BUDGET), 1);
        chk("first_valid_cycle", 32'(first_k), 3);
        n = sel ? 6 : 11;
        chk("seq_len", 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            exp_v = sel ? exp4[i] : exp5[i];
            chk("seq_val", 32'(got[i]), 32'(exp_v));
        end
        chk("end_count", obs_count, 32'(n));
        chk("done_pulses", 32'(done_cnt), 1);
        chk("done_after_last", 32'(done_after_max), 32'(!sel));
        chk("busy_fall", 32'(obs_busy), 0);
        chk("prime_hold", obs_prime, 32'(maxp));
    endtask

    initial begin
        int k;
        sel     = 1'b0;
        rst_n   = 1'b0;
        start_t = 1'b0;
        ready_t = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_prime5", 32'(prime5), 0);
        chk("rst_valid5", 32'(valid5), 0);
        chk("rst_busy5", 32'(busy5), 0);
        chk("rst_done5", 32'(done5), 0);
        chk("rst_count5", 32'(count5), 0);
        chk("rst_prime4", 32'(prime4), 0);
        chk("rst_busy4", 32'(busy4), 0);
        rst_n = 1'b1;

        // Plain sweep with ready held high
        sweep(1'b0, 1'b0);

        // Backpressure at 7 plus ignored starts during the sweep and in DONE
        sweep(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        start_t = 1'b0;
        chk("idle_after_poke_busy", 32'(busy5), 0);
        chk("idle_after_poke_count", 32'(count5), 11);
        chk("idle_after_poke_prime", 32'(prime5), 31);

        // Reset while 13 is being offered
        @(negedge clk);
        start_t = 1'b1;
        k = 0;
        @(negedge clk);
        start_t = 1'b0;
        while (k < BUDGET && !(valid5 && prime5 == 5'd13)) begin
            @(negedge clk);
            k++;
        end
        chk("wait13_timeout", 32'(k < BUDGET), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", 32'(valid5), 0);
        chk("midrst_busy", 32'(busy5), 0);
        chk("midrst_prime", 32'(prime5), 0);
        chk("midrst_count", 32'(count5), 0);
        sweep(1'b0, 1'b0);

        // WIDTH=4: composite endpoint 15
        sel = 1'b1;
        sweep(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
